// File: rtl/dotmatrix_pkg.sv
// Shared types and helpers for the 16x16 dot-matrix row scanner.
package dotmatrix_pkg;

    localparam int ROWS  = 16;
    localparam int COLS  = 16;
    localparam int ROW_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        LOAD,
        SHOW
    } scan_state_t;

    function automatic logic [ROWS-1:0] row_onehot(input logic [ROW_W-1:0] row);
        logic [ROWS-1:0] v;
        v      = '0;
        v[row] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/dotmatrix_scan.sv
// Row-scan controller: steps row_bin 0..15, latches the ROM column word, drives the matrix.
// Optional inter-row blanking is enabled with `define DOTMATRIX_BLANK_EN.
module dotmatrix_scan
    import dotmatrix_pkg::*;
#(
    parameter int ROW_DIV   = 25000,
    parameter int BLANK_CYC = 500
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [COLS-1:0]  col_in,
    output logic [ROW_W-1:0] row_bin,
    output logic [ROWS-1:0]  row_sel,
    output logic [COLS-1:0]  col_out,
    output logic             frame_start
);

    localparam int CNT_W = (ROW_DIV > 2) ? $clog2(ROW_DIV) : 1;

`ifdef DOTMATRIX_BLANK_EN
    localparam int DARK_CYC = BLANK_CYC;
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

    generate
        if (BLANK_CYC < 1 || ROW_DIV < BLANK_CYC + 3) begin : g_bad_blank
            $error("dotmatrix_scan: need BLANK_CYC >= 1 and ROW_DIV >= BLANK_CYC + 3");
        end
    endgenerate
`else
    // BLANK_CYC stays on the parameter list so both builds instantiate alike; it adds no cycles here.
    localparam int DARK_CYC = BLANK_CYC - BLANK_CYC;
`endif

    localparam int SHOW_CYC = ROW_DIV - DARK_CYC - 1;
    localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(SHOW_CYC - 1);

    generate
        if (ROW_DIV < 2) begin : g_bad_div
            $error("dotmatrix_scan: ROW_DIV must be at least 2");
        end
    endgenerate

    scan_state_t      state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [ROW_W-1:0] row_bin_nxt;
    logic [ROWS-1:0]  row_sel_nxt;
    logic [COLS-1:0]  col_out_nxt;
    logic             frame_start_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            row_bin     <= '0;
            row_sel     <= '0;
            col_out     <= '0;
            frame_start <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            row_bin     <= row_bin_nxt;
            row_sel     <= row_sel_nxt;
            col_out     <= col_out_nxt;
            frame_start <= frame_start_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        row_bin_nxt = row_bin;
        row_sel_nxt = row_sel;
        col_out_nxt = col_out;

        case (state)
            IDLE: begin
                if (en) begin
`ifdef DOTMATRIX_BLANK_EN
                    state_nxt = BLANK;
`else
                    state_nxt = LOAD;
`endif
                end
            end
`ifdef DOTMATRIX_BLANK_EN
            BLANK: begin
                if (cnt == BLANK_LAST) state_nxt = LOAD;
            end
`endif
            LOAD: begin
                state_nxt   = SHOW;
                row_sel_nxt = row_onehot(row_bin);
                col_out_nxt = col_in;
            end
            SHOW: begin
                // Row drive drops together with the row advance so the next slot starts dark.
                if (cnt == SHOW_LAST) begin
`ifdef DOTMATRIX_BLANK_EN
                    state_nxt = BLANK;
`else
                    state_nxt = LOAD;
`endif
                    row_bin_nxt = row_bin + 1'b1;
                    row_sel_nxt = '0;
                    col_out_nxt = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (!en) begin
            state_nxt   = IDLE;
            row_bin_nxt = '0;
            row_sel_nxt = '0;
            col_out_nxt = '0;
        end

        frame_start_nxt = (state_nxt == LOAD) && (row_bin_nxt == '0);
        cnt_nxt         = (state_nxt != state || state == IDLE) ? '0 : cnt + 1'b1;
    end

endmodule

// File: tb/tb_dotmatrix_scan.sv
// Scoreboard bench for dotmatrix_scan: slot-position reference model feeds a queue, negedge monitor checks.
module tb_dotmatrix_scan;
    import dotmatrix_pkg::*;

    localparam int ROW_DIV = 20;
`ifdef DOTMATRIX_BLANK_EN
    localparam int BL = 4;
`else
    localparam int BL = 0;
`endif
    localparam int FRAME = 16 * ROW_DIV;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        col_force = 1'b0;
    logic [15:0] col_in;
    logic [3:0]  row_bin;
    logic [15:0] row_sel;
    logic [15:0] col_out;
    logic        frame_start;

    // Pattern ROM stand-in, overridden with all-ones to probe column isolation.
    assign col_in = col_force ? 16'hFFFF : {12'h0, row_bin};

    dotmatrix_scan #(.ROW_DIV(ROW_DIV), .BLANK_CYC(4)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .col_in(col_in),
        .row_bin(row_bin), .row_sel(row_sel), .col_out(col_out),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        idle;
        logic [3:0]  rb;
        logic [15:0] rs;
        logic [15:0] co;
        logic        fs;
    } exp_t;

    exp_t        q[$];
    int          k = 0;           // cycles since the scan was (re)started, 0 = idle
    logic [15:0] held_col = '0;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;

    // Reference model: outputs follow directly from position within the slot and slot number.
    initial forever begin
        exp_t e;
        int   pos, row;
        @(posedge clk);
        if (k > 0 && rst_n && en && ((k - 1) % ROW_DIV) == BL)
            held_col = col_force ? 16'hFFFF : 16'(((k - 1) / ROW_DIV) % 16);
        if (!rst_n || !en) k = 0;
        else k++;
        e = '0;
        if (k == 0) begin
            e.idle = 1'b1;
        end else begin
            pos  = (k - 1) % ROW_DIV;
            row  = ((k - 1) / ROW_DIV) % 16;
            e.rb = 4'(row);
            e.fs = (pos == BL) && (row == 0);
            if (pos > BL) begin
                e.rs = 16'(1) << row;
                e.co = held_col;
            end
        end
        q.push_back(e);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at cycle %0d", name, act, want, cyc);
        end
    endtask

    initial begin
        int last_fs = -1;
        forever begin
            exp_t e;
            @(negedge clk);
            cyc++;
            if (q.size() != 0) begin
                e = q.pop_front();
                if (!rst_n) e = '0;
                if (!rst_n) e.idle = 1'b1;
                chk("row_bin", 32'(row_bin), 32'(e.rb));
                chk("row_sel", 32'(row_sel), 32'(e.rs));
                chk("col_out", 32'(col_out), 32'(e.co));
                chk("frame_start", 32'(frame_start), 32'(e.fs));
                if (e.idle) last_fs = -1;
                if (frame_start) begin
                    if (last_fs >= 0) chk("frame_spacing", 32'(cyc - last_fs), 32'(FRAME));
                    last_fs = cyc;
                end
            end else if (!rst_n) begin
                chk("reset_row_sel", 32'(row_sel), 32'h0);
                chk("reset_col_out", 32'(col_out), 32'h0);
            end
        end
    end

    task automatic step(input int n, input int toggle_odds);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            col_force = ($urandom_range(0, 9) == 0);
            if (toggle_odds > 0 && $urandom_range(1, toggle_odds) == 1) en = ~en;
        end
    endtask

    initial begin
        bit found;
        rst_n = 1'b0;
        en    = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        step(700, 0);

        // Drop enable in the middle of row 7's lit window.
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(posedge clk);
            #1;
            if (k > 0 && ((k - 1) / ROW_DIV) % 16 == 7 && ((k - 1) % ROW_DIV) > BL + 2) found = 1'b1;
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL wait_row7: got timeout want row 7 show window at cycle %0d", cyc);
        end
        en = 1'b0;
        step($urandom_range(1, 4), 0);
        en = 1'b1;
        step(400, 0);

        step(600, 80);
        en = 1'b1;
        step(50, 0);

        // Asynchronous reset in the middle of a row.
        @(posedge clk);
        #3 rst_n = 1'b0;
        step(3, 0);
        rst_n = 1'b1;
        step(400, 0);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dotmatrix_scan.md
# dotmatrix_scan

Row-scan controller for the 16×16 LED dot-matrix display in the traffic-light design. It steps a 4-bit row index through 0..15 and feeds it to the combinational pattern ROM. It captures the returned 16-bit column word and drives the matrix row and column lines with a fixed per-row dwell time. An optional blanking interval between rows suppresses ghosting.

## Interface
- `ROW_DIV`, default 25000: clock cycles per row slot (50 MHz → 2 kHz row rate, 125 Hz frame); must be ≥ `BLANK_CYC`+3.
- `BLANK_CYC`, default 500: cycles of blanking at the start of each row slot; ≥1; used only with `DOTMATRIX_BLANK_EN`.
- `clk` input 1: system clock; all logic is on the rising edge.
- `rst_n` input 1: reset, asynchronous assert, active-low.
- `en` input 1: scan enable; when low, the display is dark and the scan is parked.
- `col_in` input 16: column word from the pattern ROM for the current `row_bin`.
- `row_bin` output 4: row index to the pattern ROM (registered).
- `row_sel` output 16: one-hot row drive, active-high; bit *n* drives row *n*.
- `col_out` output 16: registered column drive, active-high.
- `frame_start` output 1: one-cycle pulse marking the start of row 0.

## Operation
- State machine with states IDLE, BLANK, LOAD and SHOW. The state type lives in the package.
- **IDLE**
  - Outputs: `row_bin`=0, `row_sel`=0, `col_out`=0, cycle counter=0.
  - When `en`=1, go to BLANK; without the macro, go to LOAD.
- **BLANK**
  - `row_sel`=0 and `col_out`=0; `row_bin` holds the upcoming row.
  - Stay for `BLANK_CYC` cycles, then go to LOAD.
- **LOAD**
  - One cycle. `col_in` is sampled and the next `col_out` = `col_in`.
  - The next `row_sel` = one-hot(`row_bin`).
  - `frame_start`=1 during this cycle iff `row_bin`==0.
- **SHOW**
  - `row_sel` and `col_out` hold.
  - Stays for the rest of the slot: `ROW_DIV`-`BLANK_CYC`-1 cycles, or `ROW_DIV`-1 cycles without the macro.
  - On exit, `row_bin` increments modulo 16 (15→0 wraps, with no extra cycles).
  - Exits to BLANK, or to LOAD without the macro.
- **Row slot length:** exactly `ROW_DIV` cycles in both builds; a frame is 16×`ROW_DIV` cycles.
- **Cycle counter:** width `$clog2(ROW_DIV)`. It resets to 0 on every state change and never exceeds `ROW_DIV`-1.
- **`en` deasserted in any state:** the next state is IDLE, and all outputs are 0 in the following cycle. A partial row is dropped, and the scan restarts at row 0 on re-enable.
- **`col_in` changes:** changes outside the LOAD cycle are ignored.

## Timing
- All outputs are registered; nothing is combinational from input to output.
- **Reset values:** state IDLE, `row_bin`=0, `row_sel`=0, `col_out`=0, `frame_start`=0.
- **`en` rises in cycle 0** (with macro):
  - BLANK covers cycles 1..`BLANK_CYC`.
  - LOAD is cycle `BLANK_CYC`+1, with `frame_start`=1 in that cycle.
  - `row_sel`/`col_out` are valid from cycle `BLANK_CYC`+2 through cycle `ROW_DIV`.
- **Pattern ROM path:** `row_bin` is stable for at least one full cycle before LOAD samples `col_in`, so the ROM path is single-cycle.
- **Reset mid-row:** outputs clear immediately (asynchronous); the scan resumes from IDLE after `rst_n` rises.

## Configuration
- `DOTMATRIX_BLANK_EN` defined:
  - The BLANK state exists.
  - Each slot has `BLANK_CYC` dark cycles, then 1 LOAD cycle, then `ROW_DIV`-`BLANK_CYC`-1 SHOW cycles.
- `DOTMATRIX_BLANK_EN` not defined:
  - The BLANK state and the `BLANK_CYC` parameter check are compiled out.
  - LOAD follows SHOW directly; the row is dark only during each LOAD cycle, plus any IDLE time.

## Structure
- Package `dotmatrix_pkg`:
  - `ROWS`=16, `COLS`=16, `ROW_W`=4.
  - Enum `scan_state_t` {IDLE, BLANK, LOAD, SHOW}.
  - A one-hot decode function for `row_sel`.
- No sub-module. The counter and FSM are inline.
- The pattern ROM stays outside and is connected by the top level via `row_bin`/`col_in`.

## Test plan
Bench parameters for all scenarios: `ROW_DIV`=20, `BLANK_CYC`=4, macro defined unless stated. The ROM model returns `col_in` = {12'h0, `row_bin`}.
- **Reset:** hold `rst_n`=0 with `en`=1 → all outputs 0. Release → `frame_start` pulses 5 cycles after the first enabled edge.
- **Normal scan:**
  - Row 3 slot → `row_sel`=16'h0008 and `col_out`=16'h0003 for exactly 15 cycles.
  - Both are 0 for the 4 cycles before that SHOW window.
- **Wrap:** after row 15's SHOW → `row_bin`=0. The next LOAD asserts `frame_start`, and pulses are spaced exactly 320 cycles apart.
- **Disable mid-row:** drop `en` during row 7 SHOW → outputs 0 on the next cycle. Re-enable → the scan restarts at row 0 with `frame_start`.
- **Column isolation:** change `col_in` to 16'hFFFF during SHOW → `col_out` is unchanged until the next LOAD.
- **Macro off:** each slot is 1 LOAD cycle plus 19 SHOW cycles, and `row_sel` is never 0 for more than 1 cycle while enabled.
